// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/ready/done handshake and operand/result bundle for serial_sub
interface serial_sub_if #(parameter int W = 4);
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         ready;
    logic [W-1:0] D;
    logic         Bout;
    logic         done;

    modport master (output start, A, B, Bin, input ready, D, Bout, done);
    modport slave  (input start, A, B, Bin, output ready, D, Bout, done);
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial unsigned subtractor, A - B - Bin one bit per clock
module serial_sub #(
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  r_sr;
    logic [W-1:0]  r_next;
    logic [CW-1:0] cnt;
    logic          br;
    logic          d;
    logic          br_next;

    // One borrow cell; the difference bit enters the result register from the top.
    always_comb begin
        d         = a_sr[0] ^ b_sr[0] ^ br;
        br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        r_next    = r_sr >> 1;
        r_next[W-1] = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            bus.D     <= '0;
            bus.Bout  <= 1'b0;
            bus.done  <= 1'b0;
            bus.ready <= 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    r_sr <= r_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bus.D     <= r_next;
                        bus.Bout  <= br_next;
                        bus.done  <= 1'b1;
                        bus.ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                // IDLE and DONE both accept; DONE falls back to IDLE after one cycle.
                default: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr      <= bus.A;
                        b_sr      <= bus.B;
                        br        <= bus.Bin;
                        cnt       <= '0;
                        bus.ready <= 1'b0;
                        state     <= SHIFT;
                    end else begin
                        bus.ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
